// File: rtl/bcd_adjust_counter.sv
// Up/down BCD adjust counter for one RTC time/date field, with hold-to-repeat stepping,
// wrap pulses and a checked parallel BCD load. Define ADJ_ACCEL_EN to enable repeat acceleration.
module bcd_adjust_counter #(
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned SEL_CODE  = 10,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 23,
  parameter int unsigned FIRST_DLY = 50_000_000,
  parameter int unsigned REP_DIV   = 25_000_000,
  parameter int unsigned ACCEL_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] en_count,
  input  logic             enUP,
  input  logic             enDOWN,
  input  logic             load,
  input  logic [7:0]       load_bcd,
  output logic [7:0]       data_bcd,
  output logic [6:0]       value,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             load_err
);

  localparam int unsigned MaxDly = (FIRST_DLY > REP_DIV) ? FIRST_DLY : REP_DIV;
  localparam int unsigned TimerW = $clog2(MaxDly + 1);
  localparam logic [TimerW-1:0] FirstDly = TimerW'(FIRST_DLY);
  localparam logic [TimerW-1:0] RepDiv   = TimerW'(REP_DIV);
  localparam logic [6:0] MinV = 7'(MIN_VAL);
  localparam logic [6:0] MaxV = 7'(MAX_VAL);

  if (MIN_VAL >= MAX_VAL || MAX_VAL > 99 || FIRST_DLY < 2 || REP_DIV < 4 || ACCEL_CNT == 0)
  begin : g_param_err
    $error("bcd_adjust_counter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StFirst, StRepeat} state_e;

  state_e              state_q;
  logic                dir_dn_q;
  logic [TimerW-1:0]   timer_q;
  logic [TimerW-1:0]   rep_period;
  logic [TimerW-1:0]   period;

  logic       sel, req_up, req_dn, req_any;
  logic [3:0] ld_tens, ld_units;
  logic [6:0] ld_bin;
  logic       ld_ok;
  logic [6:0] step_val;
  logic       step_wu, step_wd;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 7'd10);
    u = 4'(v - 7'(t) * 7'd10);
    return {t, u};
  endfunction

`ifdef ADJ_ACCEL_EN
  localparam int unsigned AccW = $clog2(ACCEL_CNT + 2);
  localparam logic [TimerW-1:0] RepFast = TimerW'(REP_DIV / 4);
  logic [AccW-1:0] acc_q;

  // Repeat steps taken in this press; saturates once acceleration kicks in.
  assign rep_period = (acc_q >= AccW'(ACCEL_CNT)) ? RepFast : RepDiv;
`else
  assign rep_period = RepDiv;
`endif

  always_comb begin
    sel     = (en_count == SEL_W'(SEL_CODE));
    req_up  = sel & enUP & ~enDOWN;
    req_dn  = sel & enDOWN & ~enUP;
    req_any = req_up | req_dn;
    period  = (state_q == StFirst) ? FirstDly : rep_period;

    ld_tens  = load_bcd[7:4];
    ld_units = load_bcd[3:0];
    ld_bin   = 7'(ld_tens) * 7'd10 + 7'(ld_units);
    ld_ok    = (ld_tens <= 4'd9) && (ld_units <= 4'd9) &&
               (int'(ld_bin) >= int'(MIN_VAL)) && (int'(ld_bin) <= int'(MAX_VAL));

    step_val = value;
    step_wu  = 1'b0;
    step_wd  = 1'b0;
    if (req_dn) begin
      if (value == MinV) begin
        step_val = MaxV;
        step_wd  = 1'b1;
      end else begin
        step_val = value - 7'd1;
      end
    end else begin
      if (value == MaxV) begin
        step_val = MinV;
        step_wu  = 1'b1;
      end else begin
        step_val = value + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      dir_dn_q <= 1'b0;
      timer_q  <= '0;
      value    <= MinV;
      data_bcd <= to_bcd(MinV);
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      load_err <= 1'b0;
`ifdef ADJ_ACCEL_EN
      acc_q    <= '0;
`endif
    end else begin
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        state_q <= StIdle;
        timer_q <= '0;
`ifdef ADJ_ACCEL_EN
        acc_q   <= '0;
`endif
        if (ld_ok) begin
          value    <= ld_bin;
          data_bcd <= load_bcd;
        end else begin
          load_err <= 1'b1;
        end
      end else if (!req_any || (state_q != StIdle && dir_dn_q != req_dn)) begin
        // Release or reversal ends the press; a reversal restarts on the next edge.
        state_q <= StIdle;
        timer_q <= '0;
`ifdef ADJ_ACCEL_EN
        acc_q   <= '0;
`endif
      end else if (state_q == StIdle || timer_q == period) begin
        value    <= step_val;
        data_bcd <= to_bcd(step_val);
        wrap_up  <= step_wu;
        wrap_dn  <= step_wd;
        timer_q  <= TimerW'(1);
        if (state_q == StIdle) begin
          state_q  <= StFirst;
          dir_dn_q <= req_dn;
        end else begin
          state_q <= StRepeat;
        end
`ifdef ADJ_ACCEL_EN
        if (state_q == StRepeat && acc_q < AccW'(ACCEL_CNT)) acc_q <= acc_q + AccW'(1);
`endif
      end else begin
        timer_q <= timer_q + TimerW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_adjust_counter.sv
// Randomised bench for bcd_adjust_counter: two field instances (0..23 and 1..12) driven from
// shared inputs and compared each cycle against a press-age reference model.
module tb_bcd_adjust_counter;

  localparam int unsigned FD = 20;
  localparam int unsigned RD = 8;
  localparam int unsigned AC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en_count = '0;
  logic       enUP = 1'b0;
  logic       enDOWN = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_bcd = '0;

  logic [7:0] data_bcd_w [2];
  logic [6:0] value_w    [2];
  logic       wrap_up_w  [2];
  logic       wrap_dn_w  [2];
  logic       load_err_w [2];

  int checks = 0;
  int errors = 0;

  int mmin  [2] = '{0, 1};
  int mmax  [2] = '{23, 12};
  int mcode [2] = '{10, 5};
  int mval  [2];
  int mage  [2];
  bit mact  [2];
  bit mdir  [2];
  bit mwu   [2];
  bit mwd   [2];
  bit merr  [2];

  always #5 clk = ~clk;

  bcd_adjust_counter #(
    .SEL_W(4), .SEL_CODE(10), .MIN_VAL(0), .MAX_VAL(23),
    .FIRST_DLY(FD), .REP_DIV(RD), .ACCEL_CNT(AC)
  ) dut0 (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .load(load), .load_bcd(load_bcd), .data_bcd(data_bcd_w[0]), .value(value_w[0]),
    .wrap_up(wrap_up_w[0]), .wrap_dn(wrap_dn_w[0]), .load_err(load_err_w[0])
  );

  bcd_adjust_counter #(
    .SEL_W(4), .SEL_CODE(5), .MIN_VAL(1), .MAX_VAL(12),
    .FIRST_DLY(FD), .REP_DIV(RD), .ACCEL_CNT(AC)
  ) dut1 (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .load(load), .load_bcd(load_bcd), .data_bcd(data_bcd_w[1]), .value(value_w[1]),
    .wrap_up(wrap_up_w[1]), .wrap_dn(wrap_dn_w[1]), .load_err(load_err_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Steps fall at press ages 0, FD, then every RD (every RD/4 after AC repeats when accelerated).
  function automatic bit is_step(int age);
    int a;
    if (age == 0) return 1'b1;
    if (age < int'(FD)) return 1'b0;
    a = age - int'(FD);
`ifdef ADJ_ACCEL_EN
    if (a <= int'(AC * RD)) return (a % int'(RD)) == 0;
    return ((a - int'(AC * RD)) % int'(RD / 4)) == 0;
`else
    return (a % int'(RD)) == 0;
`endif
  endfunction

  function automatic logic [7:0] bcd_of(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mval[i] = mmin[i];
      mact[i] = 1'b0;
      mage[i] = 0;
      mdir[i] = 1'b0;
      mwu[i]  = 1'b0;
      mwd[i]  = 1'b0;
      merr[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit sel, up, dn;
      int t, u, v;
      sel = (int'(en_count) == mcode[i]);
      up  = sel && enUP && !enDOWN;
      dn  = sel && enDOWN && !enUP;
      mwu[i]  = 1'b0;
      mwd[i]  = 1'b0;
      merr[i] = 1'b0;
      if (load) begin
        mact[i] = 1'b0;
        t = int'(load_bcd[7:4]);
        u = int'(load_bcd[3:0]);
        v = t * 10 + u;
        if (t <= 9 && u <= 9 && v >= mmin[i] && v <= mmax[i]) mval[i] = v;
        else merr[i] = 1'b1;
      end else if (!(up || dn)) begin
        mact[i] = 1'b0;
      end else if (mact[i] && mdir[i] != dn) begin
        mact[i] = 1'b0;
      end else begin
        if (!mact[i]) begin
          mact[i] = 1'b1;
          mage[i] = 0;
          mdir[i] = dn;
        end else begin
          mage[i]++;
        end
        if (is_step(mage[i])) begin
          if (dn) begin
            if (mval[i] == mmin[i]) begin
              mval[i] = mmax[i];
              mwd[i]  = 1'b1;
            end else mval[i]--;
          end else begin
            if (mval[i] == mmax[i]) begin
              mval[i] = mmin[i];
              mwu[i]  = 1'b1;
            end else mval[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("value%0d", i), 32'(value_w[i]), 32'(mval[i]));
      check($sformatf("data_bcd%0d", i), 32'(data_bcd_w[i]), 32'(bcd_of(mval[i])));
      check($sformatf("wrap_up%0d", i), 32'(wrap_up_w[i]), 32'(mwu[i]));
      check($sformatf("wrap_dn%0d", i), 32'(wrap_dn_w[i]), 32'(mwd[i]));
      check($sformatf("load_err%0d", i), 32'(load_err_w[i]), 32'(merr[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int req_kind;
    model_reset();
    #12;
    check_all();
    check("rst_bcd", 32'(data_bcd_w[0]), 32'h00);
    @(negedge clk);
    reset = 1'b0;

    // Load 23 then a single-cycle up: wraps to 00.
    load = 1'b1; load_bcd = 8'h23; tick();
    load = 1'b0; en_count = 4'd10; enUP = 1'b1; tick();
    check("wrap_to_00", 32'(data_bcd_w[0]), 32'h00);
    check("wrap_up_pulse", 32'(wrap_up_w[0]), 32'd1);
    enUP = 1'b0; tick();
    check("wrap_up_clear", 32'(wrap_up_w[0]), 32'd0);

    // Hold down from 0: 23 at t0+1, 22 at t0+21, 21 at t0+29, 20 at t0+37.
    enDOWN = 1'b1; tick();
    check("dn_wrap_23", 32'(value_w[0]), 32'd23);
    check("dn_wrap_pulse", 32'(wrap_dn_w[0]), 32'd1);
    repeat (20) tick();
    check("dn_first_rep", 32'(value_w[0]), 32'd22);
    repeat (8) tick();
    check("dn_rep1", 32'(value_w[0]), 32'd21);
    repeat (8) tick();
    check("dn_rep2", 32'(value_w[0]), 32'd20);
    enDOWN = 1'b0; tick();

    // Deselected, then both directions at once: no movement.
    en_count = 4'd9; enUP = 1'b1; repeat (100) tick();
    check("desel_hold", 32'(value_w[0]), 32'd20);
    en_count = 4'd10; enDOWN = 1'b1; repeat (30) tick();
    check("both_hold", 32'(value_w[0]), 32'd20);
    enUP = 1'b0; enDOWN = 1'b0; tick();

    // Good and bad loads.
    load = 1'b1; load_bcd = 8'h17; tick();
    check("load_17", 32'(data_bcd_w[0]), 32'h17);
    load_bcd = 8'h24; tick();
    check("load_24_err", 32'(load_err_w[0]), 32'd1);
    load_bcd = 8'h1A; tick();
    check("load_1A_err", 32'(load_err_w[0]), 32'd1);
    check("load_1A_keep", 32'(value_w[0]), 32'd17);
    load = 1'b0; tick();

    // Day/month-style field: hold down from 1 wraps to 12, then repeats/accelerates.
    en_count = 4'd5; enDOWN = 1'b1; tick();
    check("f1_wrap_12", 32'(value_w[1]), 32'd12);
    check("f1_wrap_dn", 32'(wrap_dn_w[1]), 32'd1);
    repeat (60) tick();
    enDOWN = 1'b0; tick();

    // Reset while a request is held: steps on the first edge after release.
    en_count = 4'd10; enDOWN = 1'b1; repeat (5) tick();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_step", 32'(value_w[0]), 32'd23);
    enDOWN = 1'b0; tick();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(63) == 0) begin
        req_kind = int'($urandom_range(3));
        enUP   = (req_kind == 1 || req_kind == 3);
        enDOWN = (req_kind == 2 || req_kind == 3);
        case ($urandom_range(9))
          0, 1, 2, 3: en_count = 4'd10;
          4, 5, 6, 7: en_count = 4'd5;
          default:    en_count = 4'($urandom_range(15));
        endcase
      end
      load = ($urandom_range(99) == 0);
      if ($urandom_range(1) == 0) load_bcd = {4'($urandom_range(9)), 4'($urandom_range(9))};
      else load_bcd = 8'($urandom_range(255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
